// File: rtl/score_keeper.sv
// Score accumulator with ghost-combo doubling, saturation and session high score.
// Optional extra-life pulse is enabled by defining SCORE_EXTRA_LIFE_EN.
module score_keeper #(
    parameter int unsigned MAX_SCORE      = 9999,
    parameter int unsigned PELLET_PTS     = 10,
    parameter int unsigned POWER_PTS      = 50,
    parameter int unsigned GHOST_BASE_PTS = 200,
    parameter int unsigned FRUIT_PTS      = 100,
    parameter int unsigned HISCORE_INIT   = 0,
    parameter int unsigned EXTRA_LIFE_AT  = 5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_game,
    input  logic        pellet_eaten,
    input  logic        power_eaten,
    input  logic        ghost_eaten,
    input  logic        fruit_eaten,
    output logic [15:0] score,
    output logic [15:0] high_score,
    output logic        busy,
    output logic        event_drop,
    output logic        extra_life
);

    typedef enum logic [1:0] {IDLE, ADD, CHECK} state_t;

    localparam int unsigned EV_PELLET = 0;
    localparam int unsigned EV_POWER  = 1;
    localparam int unsigned EV_GHOST  = 2;
    localparam int unsigned EV_FRUIT  = 3;

    // The renderer shows four BCD digits; the extra-life threshold must be reachable.
    if (MAX_SCORE > 9999 || EXTRA_LIFE_AT > MAX_SCORE) begin : g_bad_cfg
        $error("score_keeper: MAX_SCORE/EXTRA_LIFE_AT out of range");
    end

    state_t      state, state_nxt;
    logic [3:0]  pending, ev_in, clr_mask, sel, sel_nxt;
    logic [15:0] addend, addend_nxt, score_sat;
    logic [16:0] sum;
    logic [1:0]  combo;
    logic        drop_now;

    assign ev_in    = {fruit_eaten, ghost_eaten, power_eaten, pellet_eaten};
    assign clr_mask = (state == ADD) ? sel : '0;
    assign drop_now = |(ev_in & pending & ~clr_mask);
    assign sum      = {1'b0, score} + {1'b0, addend};
    assign score_sat = (sum > 17'(MAX_SCORE)) ? 16'(MAX_SCORE) : sum[15:0];
    assign busy     = (|pending) || (state != IDLE);

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        addend_nxt = addend;
        case (state)
            IDLE: begin
                if (|pending) begin
                    state_nxt = ADD;
                    if (pending[EV_GHOST]) begin
                        sel_nxt    = 4'b0100;
                        addend_nxt = 16'(GHOST_BASE_PTS) << combo;
                    end else if (pending[EV_FRUIT]) begin
                        sel_nxt    = 4'b1000;
                        addend_nxt = 16'(FRUIT_PTS);
                    end else if (pending[EV_POWER]) begin
                        sel_nxt    = 4'b0010;
                        addend_nxt = 16'(POWER_PTS);
                    end else begin
                        sel_nxt    = 4'b0001;
                        addend_nxt = 16'(PELLET_PTS);
                    end
                end
            end
            ADD:     state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= '0;
            addend     <= '0;
            pending    <= '0;
            combo      <= '0;
            score      <= '0;
            high_score <= 16'(HISCORE_INIT);
            event_drop <= 1'b0;
        end else if (new_game) begin
            state      <= IDLE;
            sel        <= '0;
            addend     <= '0;
            pending    <= '0;
            combo      <= '0;
            score      <= '0;
            event_drop <= 1'b0;
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            addend  <= addend_nxt;
            // A pulse arriving as its bit clears re-arms it rather than dropping.
            pending <= (pending & ~clr_mask) | ev_in;
            if (drop_now) event_drop <= 1'b1;
            if (state == ADD) begin
                score <= score_sat;
                if (sel[EV_GHOST] && combo != 2'd3) combo <= combo + 2'd1;
                if (sel[EV_POWER]) combo <= '0;
            end
            if (state == CHECK && score > high_score) high_score <= score;
        end
    end

`ifdef SCORE_EXTRA_LIFE_EN
    logic life_given;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            life_given <= 1'b0;
            extra_life <= 1'b0;
        end else if (new_game) begin
            life_given <= 1'b0;
            extra_life <= 1'b0;
        end else begin
            extra_life <= 1'b0;
            if (state == CHECK && score >= 16'(EXTRA_LIFE_AT) && !life_given) begin
                extra_life <= 1'b1;
                life_given <= 1'b1;
            end
        end
    end
`else
    assign extra_life = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper; honours SCORE_EXTRA_LIFE_EN if defined.
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        new_game, pellet_eaten, power_eaten, ghost_eaten, fruit_eaten;
    logic [15:0] score, high_score;
    logic        busy, event_drop, extra_life;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned el_count = 0;
    int unsigned busy_cycles;

`ifdef SCORE_EXTRA_LIFE_EN
    localparam int unsigned EL_ON = 1;
`else
    localparam int unsigned EL_ON = 0;
`endif

    localparam logic [3:0] PEL = 4'b0001, PWR = 4'b0010, GHO = 4'b0100, FRU = 4'b1000;

    score_keeper #(
        .MAX_SCORE      (9999),
        .PELLET_PTS     (10),
        .POWER_PTS      (50),
        .GHOST_BASE_PTS (200),
        .FRUIT_PTS      (100),
        .HISCORE_INIT   (0),
        .EXTRA_LIFE_AT  (5000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .new_game     (new_game),
        .pellet_eaten (pellet_eaten),
        .power_eaten  (power_eaten),
        .ghost_eaten  (ghost_eaten),
        .fruit_eaten  (fruit_eaten),
        .score        (score),
        .high_score   (high_score),
        .busy         (busy),
        .event_drop   (event_drop),
        .extra_life   (extra_life)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (extra_life) el_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_ev(input logic [3:0] ev);
        {fruit_eaten, ghost_eaten, power_eaten, pellet_eaten} = ev;
    endtask

    // Called at a negedge; the following posedge samples the events.
    task automatic pulse(input logic [3:0] ev);
        set_ev(ev);
        @(negedge clk);
        set_ev(4'b0000);
    endtask

    task automatic start_game();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 64; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check(tag, busy, 0);
    endtask

    task automatic event_n(input logic [3:0] ev, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            pulse(ev);
            wait_idle("idle_seq");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        new_game = 1'b0;
        set_ev(4'b0000);
        repeat (3) @(negedge clk);
        check("rst_score", score, 0);
        check("rst_high", high_score, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", event_drop, 0);
        check("rst_xlife", extra_life, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Isolated pellet latency
        pulse(PEL);
        check("pel_busy_n", busy, 1);
        check("pel_score_n", score, 0);
        @(negedge clk);
        check("pel_score_n1", score, 0);
        @(negedge clk);
        check("pel_score_n2", score, 10);
        check("pel_high_n2", high_score, 0);
        @(negedge clk);
        check("pel_high_n3", high_score, 10);
        check("pel_busy_n3", busy, 0);

        // Ghost combo chain
        start_game();
        check("ng_score", score, 0);
        check("ng_high", high_score, 10);
        pulse(PWR);
        repeat (9) @(negedge clk);
        check("pwr_score", score, 50);
        for (int i = 0; i < 5; i++) begin
            pulse(GHO);
            repeat (9) @(negedge clk);
            if (i == 3) check("combo_3050", score, 3050);
        end
        check("combo_4650", score, 4650);
        check("combo_high", high_score, 4650);
        check("combo_busy", busy, 0);
        check("combo_xlife_cnt", el_count, 0);

        // All four events at once
        start_game();
        pulse(PEL | PWR | GHO | FRU);
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_cycles++;
            if (i == 2)  check("multi_ghost", score, 200);
            if (i == 5)  check("multi_fruit", score, 300);
            if (i == 8)  check("multi_power", score, 350);
            if (i == 11) check("multi_pellet", score, 360);
            @(negedge clk);
        end
        check("multi_busy_cycles", busy_cycles, 12);
        check("multi_score", score, 360);
        check("multi_drop", event_drop, 0);
        check("multi_high", high_score, 4650);

        // Mid-run reset, then back-to-back pellet drop
        pulse(GHO);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("async_rst_score", score, 0);
        check("async_rst_high", high_score, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_ev(PEL);
        @(negedge clk);
        @(negedge clk);
        set_ev(4'b0000);
        wait_idle("idle_drop");
        check("drop_flag", event_drop, 1);
        check("drop_score", score, 10);
        check("drop_high", high_score, 10);
        start_game();
        check("drop_ng_score", score, 0);
        check("drop_ng_flag", event_drop, 0);
        check("drop_ng_high", high_score, 10);

        // new_game aborts an in-flight ADD and swallows a same-edge pellet
        pulse(FRU);
        @(negedge clk);
        new_game = 1'b1;
        set_ev(PEL);
        @(negedge clk);
        new_game = 1'b0;
        set_ev(4'b0000);
        check("abort_busy", busy, 0);
        repeat (4) @(negedge clk);
        check("abort_score", score, 0);
        check("abort_high", high_score, 10);

        // Saturation
        event_n(GHO, 8);
        check("sat_9400", score, 9400);
        check("sat_xlife_cnt", el_count, EL_ON);
        event_n(FRU, 5);
        event_n(PEL, 9);
        check("sat_9990", score, 9990);
        event_n(FRU, 1);
        check("sat_fruit", score, 9999);
        event_n(PEL, 1);
        check("sat_pellet", score, 9999);
        check("sat_high", high_score, 9999);
        check("sat_xlife_once", el_count, EL_ON);

        // Extra life re-armed by new_game
        start_game();
        event_n(GHO, 5);
        check("xl2_4600", score, 4600);
        check("xl2_cnt_before", el_count, EL_ON);
        event_n(GHO, 1);
        check("xl2_6200", score, 6200);
        check("xl2_cnt_after", el_count, 2 * EL_ON);
        check("xl2_high", high_score, 9999);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Upstream producer of the 16-bit score consumed by the on-screen text/score renderer. It accumulates points from single-cycle game events, applies ghost-combo doubling and saturation, and tracks the session high score. Events are latched into pending flags and drained by a small FSM, one event per 3-cycle pass. Outputs are registered and stable between updates, so the renderer can sample them on any pixel.

Parameters:
MAX_SCORE, 9999, saturation ceiling; must fit 4 BCD digits for the renderer.
PELLET_PTS, 10, points per pellet.
POWER_PTS, 50, points per power pellet.
GHOST_BASE_PTS, 200, ghost points at combo 0; doubled per combo step.
FRUIT_PTS, 100, points per fruit.
HISCORE_INIT, 0, high_score value after reset.
EXTRA_LIFE_AT, 5000, score threshold for the extra-life pulse (optional feature only).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
new_game  in  1  pulse; clears the per-game state
pellet_eaten  in  1  pulse; event input
power_eaten  in  1  pulse; event input; also restarts the ghost combo
ghost_eaten  in  1  pulse; event input
fruit_eaten  in  1  pulse; event input
score  out  16  current score, registered
high_score  out  16  session maximum, registered
busy  out  1  high while any event is pending or the FSM is not in IDLE
event_drop  out  1  sticky; an event pulse arrived while its pending flag was already set
extra_life  out  1  one-cycle pulse (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): score=0, high_score=HISCORE_INIT, combo=0, pending=0, state=IDLE, event_drop=0, extra_life=0, busy=0.
- Capture: on every edge, each event pulse ORs into its pending bit.
  - If the bit is already set and not being cleared on that edge, event_drop is set.
  - An event pulse on the same edge its bit clears re-sets the bit; this is not a drop.
- Arbitration priority: ghost > fruit > power > pellet.
- FSM:
  - IDLE: if pending != 0, select the highest-priority event, register its addend, go to ADD.
    - Ghost addend = GHOST_BASE_PTS << combo.
  - ADD: score <= min(score + addend, MAX_SCORE), using a 17-bit sum before the compare. Clear the selected pending bit.
    - Ghost: combo <= min(combo+1, 3).
    - Power: combo <= 0.
    - Go to CHECK.
  - CHECK: if score > high_score, then high_score <= score. Go to IDLE.
- Combo values: 200, 400, 800, 1600. Stays at 1600 after the fourth ghost until a power event is processed.
- Latency for an isolated event sampled at edge N:
  - pending set at N;
  - ADD entered at N+1;
  - score updated at N+2;
  - high_score updated at N+3;
  - busy low after N+3.
- Simultaneous power+ghost pulses: the ghost is scored at the current combo first, then power resets combo.
- Saturation: score never exceeds MAX_SCORE. Once score reaches MAX_SCORE, further events still clear their pending bits but leave score unchanged.
- new_game (synchronous, highest priority):
  - score=0, combo=0, pending=0, state=IDLE, event_drop=0, extra-life flag cleared.
  - high_score is retained.
  - Event pulses on the same edge are discarded.
  - An in-flight ADD/CHECK is aborted; no high_score update from it.
- rst_n asserted mid-operation: immediate return to reset values.

Optional Feature:
SCORE_EXTRA_LIFE_EN:
- Defined: a per-game flag records whether the extra life was awarded. In CHECK, if score >= EXTRA_LIFE_AT and the flag is clear, extra_life pulses high for exactly one cycle and the flag is set. new_game clears the flag. The award happens at most once per game.
- Undefined: extra_life is tied to 0 and no flag register exists.

Test Plan:
- Reset, then one pellet_eaten pulse -> score=10 two edges after sampling, high_score=10 one edge later, busy low afterwards.
- power_eaten, then 5 ghost_eaten pulses spaced 10 cycles apart -> score = 50+200+400+800+1600+1600 = 4650.
- pellet, power, ghost and fruit pulsed on the same cycle from reset -> scored in order ghost(200), fruit(100), power(50), pellet(10); final score=360; event_drop=0; busy high for 12 cycles.
- Two pellet pulses 1 cycle apart -> second dropped, event_drop=1, score=10. Then new_game -> score=0, event_drop=0, high_score=10.
- Preload score near the ceiling (9990) via repeated events, then a fruit event -> score=9999. A following pellet leaves score at 9999.
- With SCORE_EXTRA_LIFE_EN: cross 5000 -> one extra_life pulse in CHECK; further events give no pulse; after new_game, crossing 5000 again pulses again. Without the macro: extra_life is always 0.
